// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM DAC: carrier modes, direction states,
// sample code conversion and parameter sanity checks.
package pwm_multi_pkg;

  localparam int unsigned MODE_EDGE   = 0;
  localparam int unsigned MODE_CENTER = 1;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } dir_e;

  // Two's complement to offset binary is a flip of the sample MSB.
  function automatic logic [31:0] to_offset(input logic [31:0] d, input int unsigned dw,
                                            input bit signed_in);
    return signed_in ? (d ^ (32'(1) << (dw - 1))) : d;
  endfunction

  function automatic bit widths_ok(input int unsigned dw, input int unsigned cw);
    return (cw >= 1) && (dw >= cw) && (dw <= 32);
  endfunction

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: sample conversion, active compare register and output flop.
module pwm_ch_cmp
  import pwm_multi_pkg::*;
#(
  parameter int unsigned DW        = 12,
  parameter int unsigned CW        = 10,
  parameter int unsigned SIGNED_IN = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          load,
  input  logic [DW-1:0] hold_data,
  input  logic [CW-1:0] cnt,
  output logic          pwm
);

  localparam int unsigned SHIFT = DW - CW;

  logic [DW-1:0] u;
  logic [CW-1:0] cmp_new;
  logic [CW-1:0] cmp_q;
  logic [CW-1:0] cmp_eff;

  // A sample loaded at a boundary already governs the first cycle of its period.
  always_comb begin
    u       = DW'(to_offset(32'(hold_data), DW, SIGNED_IN != 0));
    cmp_new = CW'(u >> SHIFT);
    cmp_eff = load ? cmp_new : cmp_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_q <= '0;
      pwm   <= 1'b0;
    end else begin
      if (load) cmp_q <= cmp_new;
      pwm <= enable && ({1'b0, cnt} < {1'b0, cmp_eff});
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel double-buffered PWM DAC: shared carrier counter, sample holding
// register with valid/ready intake, underrun flag and period-start strobe.
module pwm_multi_ch
  import pwm_multi_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned COUNTER_WIDTH  = 10,
  parameter int unsigned SIGNED_IN      = 1,
  parameter int unsigned CENTER_ALIGNED = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic [COUNTER_WIDTH-1:0]       period,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
  input  logic                           clear_underrun,
  output logic [NUM_CH-1:0]              pwm_out,
  output logic                           period_start,
  output logic                           underrun
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = COUNTER_WIDTH;

  if (!widths_ok(DW, CW)) begin : g_bad_width
    $error("pwm_multi_ch: need 1 <= COUNTER_WIDTH <= DATA_WIDTH <= 32");
  end

  dir_e                 dir_q, dir_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        period_sh;
  logic [CW-1:0]        p_eff;
  logic [NUM_CH*DW-1:0] hold_q;
  logic                 hold_full;
  logic                 boundary;
  logic                 accept;
  logic                 load;

  // Carrier next state; the boundary cycle already steps with the newly sampled period.
  always_comb begin
    hold_full = !in_ready;
    boundary  = enable && (cnt_q == '0);
    accept    = in_valid && in_ready;
    load      = boundary && hold_full;
    p_eff     = boundary ? period : period_sh;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (!enable) begin
      cnt_d = '0;
      dir_d = ST_UP;
    end else if (CENTER_ALIGNED == MODE_CENTER) begin
      case (dir_q)
        ST_UP: begin
          if (cnt_q >= p_eff) begin
            if (p_eff != '0) begin
              cnt_d = cnt_q - CW'(1);
              dir_d = (cnt_q > CW'(1)) ? ST_DOWN : ST_UP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DOWN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) dir_d = ST_UP;
        end
        default: begin
          cnt_d = '0;
          dir_d = ST_UP;
        end
      endcase
    end else begin
      cnt_d = (cnt_q >= p_eff) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      dir_q        <= ST_UP;
      period_sh    <= '1;
      hold_q       <= '0;
      in_ready     <= 1'b1;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_start <= boundary;
      if (boundary) period_sh <= period;
      if (accept) hold_q <= in_data;
      if (accept) in_ready <= 1'b0;
      else if (load) in_ready <= 1'b1;
      if (boundary && !hold_full) underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_ch_cmp #(
      .DW       (DW),
      .CW       (CW),
      .SIGNED_IN(SIGNED_IN)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .enable   (enable),
      .load     (load),
      .hold_data(hold_q[k*DW +: DW]),
      .cnt      (cnt_q),
      .pwm      (pwm_out[k])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench: edge-aligned signed instance and centre-aligned unsigned instance,
// duty/period counted per carrier period against arithmetic expectations.
module tb_pwm_multi_ch;

  localparam int DW  = 12;
  localparam int CW  = 10;
  localparam int CDW = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            e_en, e_valid, e_ready, e_clr, e_ps, e_ur;
  logic [CW-1:0]   e_per;
  logic [2*DW-1:0] e_data;
  logic [1:0]      e_pwm;
  logic             c_en, c_valid, c_ready, c_clr, c_ps, c_ur;
  logic [CW-1:0]    c_per;
  logic [2*CDW-1:0] c_data;
  logic [1:0]       c_pwm;

  int tests = 0;
  int fails = 0;
  int e_acc = 0;
  int c_acc = 0;
  bit e_keep = 1'b0;

  pwm_multi_ch #(.NUM_CH(2), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .SIGNED_IN(1),
                 .CENTER_ALIGNED(0)) dut_e (
    .clk(clk), .rstn(rstn), .enable(e_en), .period(e_per), .in_valid(e_valid),
    .in_ready(e_ready), .in_data(e_data), .clear_underrun(e_clr), .pwm_out(e_pwm),
    .period_start(e_ps), .underrun(e_ur));

  pwm_multi_ch #(.NUM_CH(2), .DATA_WIDTH(CDW), .COUNTER_WIDTH(CW), .SIGNED_IN(0),
                 .CENTER_ALIGNED(1)) dut_c (
    .clk(clk), .rstn(rstn), .enable(c_en), .period(c_per), .in_valid(c_valid),
    .in_ready(c_ready), .in_data(c_data), .clear_underrun(c_clr), .pwm_out(c_pwm),
    .period_start(c_ps), .underrun(c_ur));

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; an offered sample seen with ready high is taken at this edge.
  task automatic tick();
    bit ea, ca;
    ea = e_valid && e_ready;
    ca = c_valid && c_ready;
    @(posedge clk);
    #1;
    if (ea) begin e_acc++; if (!e_keep) e_valid = 1'b0; end
    if (ca) begin c_acc++; c_valid = 1'b0; end
  endtask

  function automatic int ref_cmp_s(input int d);
    return (d + 2048) / 4;
  endfunction

  function automatic int exp_edge(input int cmp, input int p);
    return (cmp < p + 1) ? cmp : p + 1;
  endfunction

  function automatic int exp_ctr(input int cmp, input int p);
    if (cmp == 0) return 0;
    return (cmp > p) ? 2 * p : 2 * cmp - 1;
  endfunction

  task automatic push_e(input int d0, input int d1);
    e_data  = {DW'(d1), DW'(d0)};
    e_valid = 1'b1;
  endtask

  task automatic push_c(input int d0, input int d1);
    c_data  = {CDW'(d1), CDW'(d0)};
    c_valid = 1'b1;
  endtask

  task automatic wait_ps_e();
    int n = 0;
    do begin tick(); n++; end while (!e_ps && n < 5000);
    if (!e_ps) chk("e_ps_timeout", 0, 1);
  endtask

  task automatic wait_ps_c();
    int n = 0;
    do begin tick(); n++; end while (!c_ps && n < 5000);
    if (!c_ps) chk("c_ps_timeout", 0, 1);
  endtask

  task automatic measure_e(input int n, output int h0, output int h1, output int psn);
    h0 = 0; h1 = 0; psn = 0;
    for (int i = 0; i < n; i++) begin
      if (e_pwm[0]) h0++;
      if (e_pwm[1]) h1++;
      if (e_ps) psn++;
      tick();
    end
  endtask

  task automatic measure_c(input int n, output int h0, output int h1, output int psn,
                           output logic [63:0] m0);
    h0 = 0; h1 = 0; psn = 0; m0 = '0;
    for (int i = 0; i < n; i++) begin
      if (c_pwm[0]) begin h0++; if (i < 64) m0[i] = 1'b1; end
      if (c_pwm[1]) h1++;
      if (c_ps) psn++;
      tick();
    end
  endtask

  initial begin
    int h0, h1, psn, cur_p, np, d0, d1, acc0, cmp0, cmp1, cnt;
    logic [63:0] m0, mexp;
    rstn = 1'b0;
    e_en = 0; e_valid = 0; e_clr = 0; e_per = '0; e_data = '0;
    c_en = 0; c_valid = 0; c_clr = 0; c_per = '0; c_data = '0;
    #22;
    chk("rst_pwm", e_pwm, 0);
    chk("rst_ps", e_ps, 0);
    chk("rst_ur", e_ur, 0);
    chk("rst_ready", e_ready, 1);
    chk("rst_c_ready", c_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // Edge, signed: 0 -> 50 %, -2048 -> always low
    push_e(0, -2048);
    tick();
    chk("hold_full_ready", e_ready, 0);
    e_per = 10'd1023;
    e_en  = 1'b1;
    wait_ps_e();
    measure_e(1024, h0, h1, psn);
    chk("t1_ch0_high", h0, 512);
    chk("t1_ch1_high", h1, 0);
    chk("t1_ps_count", psn, 1);
    chk("t1_period_end", e_ps, 1);
    chk("t4_underrun_set", e_ur, 1);
    measure_e(1024, h0, h1, psn);
    chk("t4_duty_held", h0, 512);
    e_clr = 1'b1;
    tick();
    e_clr = 1'b0;
    chk("t4_underrun_clr", e_ur, 0);

    // Near full scale, then a short period makes the same sample saturate high
    wait_ps_e();
    push_e(2047, 0);
    measure_e(1024, h0, h1, psn);
    e_per = 10'd99;
    push_e(2047, 0);
    measure_e(1024, h0, h1, psn);
    chk("t2_ch0_1023", h0, 1023);
    chk("t2_ch1_512", h1, 512);
    measure_e(100, h0, h1, psn);
    chk("t2_ch0_sat", h0, 100);
    chk("t2_ch1_sat", h1, 100);
    chk("t2_period_100", e_ps, 1);

    // Random period and data changes, applied together at the next boundary
    cur_p = 99;
    for (int it = 0; it < 5; it++) begin
      np = int'($urandom_range(200, 1));
      d0 = int'($urandom_range(4095, 0)) - 2048;
      d1 = int'($urandom_range(4095, 0)) - 2048;
      e_per = CW'(np);
      push_e(d0, d1);
      measure_e(cur_p + 1, h0, h1, psn);
      measure_e(np + 1, h0, h1, psn);
      chk("rnd_ch0", h0, exp_edge(ref_cmp_s(d0), np));
      chk("rnd_ch1", h1, exp_edge(ref_cmp_s(d1), np));
      chk("rnd_period", e_ps, 1);
      cur_p = np;
    end

    // Continuous in_valid: one accept per 16-cycle period
    e_per = 10'd15;
    measure_e(cur_p + 1, h0, h1, psn);
    e_keep = 1'b1;
    push_e(0, -2048);
    acc0 = e_acc;
    for (int i = 0; i < 64; i++) begin
      if (i == 5) chk("t5_ready_low", e_ready, 0);
      tick();
    end
    chk("t5_accepts", e_acc - acc0, 4);
    e_keep  = 1'b0;
    e_valid = 1'b0;

    // P == 0: every cycle is a boundary, output high iff cmp > 0
    e_per = '0;
    measure_e(16, h0, h1, psn);
    chk("p0_ps", e_ps, 1);
    e_clr = 1'b1;
    tick();
    e_clr = 1'b0;
    chk("p0_set_wins", e_ur, 1);
    chk("p0_pwm_a", e_pwm, 2'b01);
    push_e(-2048, 2047);
    tick();
    tick();
    chk("p0_pwm_b", e_pwm, 2'b10);
    chk("p0_ps_b", e_ps, 1);

    // Enable low: outputs low, no boundaries, intake still allowed
    e_en = 1'b0;
    tick();
    chk("dis_pwm", e_pwm, 0);
    tick();
    chk("dis_ps", e_ps, 0);
    push_e(0, 0);
    tick();
    chk("dis_intake", e_ready, 0);

    // Reset in the middle of a high pulse
    e_per = 10'd1023;
    e_en  = 1'b1;
    wait_ps_e();
    push_e(0, 0);
    tick();
    for (int i = 0; i < 100; i++) tick();
    chk("t6_mid_pulse", e_pwm[0], 1);
    rstn = 1'b0;
    #1;
    chk("t6_pwm_low", e_pwm, 0);
    chk("t6_ready", e_ready, 1);
    chk("t6_ur", e_ur, 0);
    chk("t6_ps", e_ps, 0);
    e_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Centre-aligned, unsigned DW == CW: P = 8, cmp = 3 and 5
    push_c(3, 5);
    tick();
    c_per = 10'd8;
    c_en  = 1'b1;
    wait_ps_c();
    measure_c(16, h0, h1, psn, m0);
    mexp = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = (i <= 8) ? i : 16 - i;
      if (cnt < 3) mexp[i] = 1'b1;
    end
    chk("t3_ch0_high", h0, 5);
    chk("t3_ch1_high", h1, 9);
    chk("t3_symmetry", m0, mexp);
    chk("t3_ps_count", psn, 1);
    chk("t3_period_16", c_ps, 1);
    chk("t3_underrun", c_ur, 1);

    cur_p = 8;
    for (int it = 0; it < 4; it++) begin
      np   = int'($urandom_range(40, 1));
      cmp0 = int'($urandom_range(1023, 0)) % (np + 3);
      cmp1 = int'($urandom_range(1023, 0));
      c_per = CW'(np);
      push_c(cmp0, cmp1);
      measure_c(2 * cur_p, h0, h1, psn, m0);
      measure_c(2 * np, h0, h1, psn, m0);
      chk("crnd_ch0", h0, exp_ctr(cmp0, np));
      chk("crnd_ch1", h1, exp_ctr(cmp1, np));
      chk("crnd_period", c_ps, 1);
      cur_p = np;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
